// File: rtl/block_acc_scheduler.sv
// block_acc_scheduler
//   Sequences the 2x2 FP32 block accumulator for one output block of a tiled
//   matmul. Each job clears the accumulator and then issues K accumulate ops,
//   one per block product taken from the multiplier stage. When all K sums have
//   landed, it raises a result handshake.
//
// Parameters
//   KW          width of job_k / k_count (K = 0 .. 2^KW-1)
//   CLR_CYCLES  cycles waited after acc_reset drops before the first acc_start (>=2)
//   TIMEOUT     max cycles spent waiting for acc_done before abort (>=1)
//
// Optional feature (compile-time macro ACC_TIMEOUT_EN)
//   Defined:   a watchdog aborts a hung accumulate, pulses acc_reset and sets res_err.
//   Undefined: the block waits indefinitely for acc_done, and res_err is tied low.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   job_start, job_k      job request with product count; sampled only when idle
//   job_busy              high whenever a job is in progress or a result is pending
//   prod_valid/prod_ready upstream product handshake; ready is a one-cycle consume pulse
//   acc_start             one-cycle start pulse to the accumulator
//   acc_reset             level clear to the accumulator (high during reset)
//   acc_done              accumulator done level; may stay high for several cycles
//   k_count               number of products accumulated in the current job
//   res_valid/res_ack     result handshake; res_valid is held until res_ack
//   res_err               job aborted by timeout, valid while res_valid
module block_acc_scheduler #(
  parameter int unsigned KW         = 8,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          job_start,
  input  logic [KW-1:0] job_k,
  output logic          job_busy,
  input  logic          prod_valid,
  output logic          prod_ready,
  output logic          acc_start,
  output logic          acc_reset,
  input  logic          acc_done,
  output logic [KW-1:0] k_count,
  output logic          res_valid,
  input  logic          res_ack,
  output logic          res_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_PROD,
    S_WAIT_ACC,
    S_DRAIN,
    S_RESULT
  } state_t;

  localparam int unsigned CLR_W = $clog2(CLR_CYCLES + 1);

  state_t          state, state_nx;
  logic [KW-1:0]   k_target, k_target_nx;
  logic [KW-1:0]   k_cnt, k_cnt_nx;
  logic [CLR_W-1:0] clr_cnt, clr_cnt_nx;
  logic            acc_reset_q, acc_reset_nx;
  logic            acc_start_q, acc_start_nx;
  logic            prod_ready_q, prod_ready_nx;
  logic            done_q;
  logic            done_rise;
  logic            timeout_hit;

  // A held acc_done must count exactly once, so only its rising edge is used.
  assign done_rise = acc_done & ~done_q;

`ifdef ACC_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt, to_cnt_nx;
  logic            res_err_q, res_err_nx;

  // to_cnt counts cycles already spent in S_WAIT_ACC; the abort is taken on the
  // TIMEOUT-th cycle without an acc_done edge.
  assign timeout_hit = (state == S_WAIT_ACC) && !done_rise &&
                       (to_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    to_cnt_nx  = '0;
    res_err_nx = res_err_q;
    if (state == S_WAIT_ACC && !done_rise) begin
      to_cnt_nx = to_cnt + 1'b1;
    end
    if (state == S_IDLE && job_start) begin
      res_err_nx = 1'b0;
    end else if (timeout_hit) begin
      res_err_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt    <= '0;
      res_err_q <= 1'b0;
    end else begin
      to_cnt    <= to_cnt_nx;
      res_err_q <= res_err_nx;
    end
  end

  assign res_err = res_err_q;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign res_err        = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_nx      = state;
    k_target_nx   = k_target;
    k_cnt_nx      = k_cnt;
    clr_cnt_nx    = clr_cnt;
    acc_reset_nx  = 1'b0;
    acc_start_nx  = 1'b0;
    prod_ready_nx = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (job_start) begin
          k_target_nx  = job_k;
          k_cnt_nx     = '0;
          clr_cnt_nx   = '0;
          acc_reset_nx = 1'b1;
          state_nx     = S_CLEAR;
        end
      end

      // First S_CLEAR cycle carries acc_reset=1; CLR_CYCLES quiet cycles follow.
      S_CLEAR: begin
        if (clr_cnt == CLR_W'(CLR_CYCLES)) begin
          state_nx = (k_target == '0) ? S_RESULT : S_WAIT_PROD;
        end else begin
          clr_cnt_nx = clr_cnt + 1'b1;
        end
      end

      // The accumulator restarts on a start seen while done is still high,
      // so a start is only issued once done has dropped.
      S_WAIT_PROD: begin
        if (prod_valid && !acc_done) begin
          acc_start_nx = 1'b1;
          state_nx     = S_WAIT_ACC;
        end
      end

      S_WAIT_ACC: begin
        if (done_rise) begin
          prod_ready_nx = 1'b1;
          k_cnt_nx      = k_cnt + 1'b1;
          state_nx      = S_DRAIN;
        end else if (timeout_hit) begin
          acc_reset_nx = 1'b1;
          state_nx     = S_RESULT;
        end
      end

      // k_count is never incremented past k_target, so the exact compare
      // cannot wrap even for K = 2^KW-1.
      S_DRAIN: begin
        if (!acc_done) begin
          state_nx = (k_cnt == k_target) ? S_RESULT : S_WAIT_PROD;
        end
      end

      S_RESULT: begin
        if (res_ack) begin
          state_nx = S_IDLE;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      k_target     <= '0;
      k_cnt        <= '0;
      clr_cnt      <= '0;
      acc_reset_q  <= 1'b1;
      acc_start_q  <= 1'b0;
      prod_ready_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_nx;
      k_target     <= k_target_nx;
      k_cnt        <= k_cnt_nx;
      clr_cnt      <= clr_cnt_nx;
      acc_reset_q  <= acc_reset_nx;
      acc_start_q  <= acc_start_nx;
      prod_ready_q <= prod_ready_nx;
      done_q       <= acc_done;
    end
  end

  assign job_busy   = (state != S_IDLE);
  assign res_valid  = (state == S_RESULT);
  assign acc_reset  = acc_reset_q;
  assign acc_start  = acc_start_q;
  assign prod_ready = prod_ready_q;
  assign k_count    = k_cnt;

endmodule

// File: tb/tb_block_acc_scheduler.sv
// tb_block_acc_scheduler
//   Drives block_acc_scheduler with a behavioural upstream product source and a
//   behavioural accumulator (random latency and done-hold). Each job is checked
//   for start/ready counts, final k_count, the accumulated lane sums and the
//   result handshake. Define ACC_TIMEOUT_EN for both files to cover the watchdog.
module tb_block_acc_scheduler;
  localparam int unsigned KW  = 8;
  localparam int unsigned CLR = 2;
  localparam int unsigned TO  = 10;
  localparam int unsigned NP  = 2048;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          job_start;
  logic [KW-1:0] job_k;
  logic          job_busy;
  logic          prod_valid = 1'b0;
  logic          prod_ready;
  logic          acc_start;
  logic          acc_reset;
  logic          acc_done = 1'b0;
  logic [KW-1:0] k_count;
  logic          res_valid;
  logic          res_ack;
  logic          res_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  block_acc_scheduler #(
    .KW        (KW),
    .CLR_CYCLES(CLR),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .job_start (job_start),
    .job_k     (job_k),
    .job_busy  (job_busy),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .acc_start (acc_start),
    .acc_reset (acc_reset),
    .acc_done  (acc_done),
    .k_count   (k_count),
    .res_valid (res_valid),
    .res_ack   (res_ack),
    .res_err   (res_err)
  );

  // Product stream (four lanes a11..a22 per block) and accumulator model state.
  int prods [NP][4];
  int sum [4];
  int prod_idx    = 0;
  int n_start     = 0;
  int n_ready     = 0;
  int n_bad_start = 0;
  int cd = 0;
  int hd = 0;
  // Model configuration, written only by the stimulus block.
  int done_lat   = 4;
  int done_hold  = 1;
  bit never_done = 1'b0;
  bit pv_always  = 1'b1;
  bit pv_en      = 1'b0;

  // Upstream source and accumulator model, evaluated away from the active edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      acc_done   = 1'b0;
      prod_valid = 1'b0;
      cd = 0;
      hd = 0;
      for (int l = 0; l < 4; l++) sum[l] = 0;
    end else begin
      if (acc_reset) begin
        for (int l = 0; l < 4; l++) sum[l] = 0;
      end
      if (acc_start) begin
        n_start++;
        if (acc_done) n_bad_start++;
        if (prod_idx < NP) begin
          for (int l = 0; l < 4; l++) sum[l] = sum[l] + prods[prod_idx][l];
        end
        cd = done_lat;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0 && !never_done) begin
          acc_done = 1'b1;
          hd = done_hold;
        end
      end else if (acc_done) begin
        hd--;
        if (hd <= 0) acc_done = 1'b0;
      end
      if (prod_ready) begin
        n_ready++;
        prod_idx++;
      end
      prod_valid = pv_en && (pv_always || ($urandom_range(0, 2) != 0));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One complete job: request, wait for the result, check it, acknowledge.
  // poke: pulse job_start while busy (must be ignored).
  // ack_start: raise job_start together with res_ack (must not be accepted).
  task automatic run_job(input int k, input int lat, input int hold, input bit always_v,
                         input bit poke, input bit ack_start);
    int s0, r0, base, cyc;
    int exp_sum [4];
    done_lat  = lat;
    done_hold = hold;
    pv_always = always_v;
    pv_en     = 1'b1;
    s0   = n_start;
    r0   = n_ready;
    base = prod_idx;
    job_k     = KW'(k);
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    chk("job_busy_after_start", job_busy, 1);
    chk("k_count_after_start", k_count, 0);
    chk("res_err_after_start", res_err, 0);
    cyc = 0;
    while (!res_valid && cyc < 20000) begin
      job_start = poke && (cyc == 5);
      if (poke && cyc == 5) job_k = KW'(k + 4);
      @(negedge clk);
      cyc++;
    end
    job_start = 1'b0;
    chk("res_valid", res_valid, 1);
    chk("k_count_final", k_count, k);
    chk("acc_start_count", n_start - s0, k);
    chk("prod_ready_count", n_ready - r0, k);
    chk("start_while_done", n_bad_start, 0);
    chk("res_err_ok", res_err, 0);
    for (int l = 0; l < 4; l++) exp_sum[l] = 0;
    for (int i = base; i < base + k; i++) begin
      for (int l = 0; l < 4; l++) exp_sum[l] += prods[i][l];
    end
    for (int l = 0; l < 4; l++) chk($sformatf("lane_sum%0d", l), sum[l], exp_sum[l]);
    repeat (2) @(negedge clk);
    chk("res_valid_held", res_valid, 1);
    res_ack   = 1'b1;
    job_start = ack_start;
    @(negedge clk);
    res_ack   = 1'b0;
    job_start = 1'b0;
    chk("res_valid_drop", res_valid, 0);
    chk("job_busy_drop", job_busy, 0);
    pv_en = 1'b0;
    @(negedge clk);
    chk("idle_stays", job_busy, 0);
  endtask

  initial begin
    int s0, cyc;
    reset_n   = 1'b0;
    job_start = 1'b0;
    job_k     = '0;
    res_ack   = 1'b0;
    for (int i = 0; i < NP; i++) begin
      for (int l = 0; l < 4; l++) prods[i][l] = int'($urandom_range(0, 1000));
    end

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_acc_reset", acc_reset, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_job_busy", job_busy, 0);
    chk("rst_k_count", k_count, 0);
    chk("rst_acc_start", acc_start, 0);
    chk("rst_prod_ready", prod_ready, 0);
    chk("rst_res_err", res_err, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", job_busy, 0);

    // Basic K=3 job, done 4 cycles after start.
    run_job(3, 4, 1, 1'b1, 1'b0, 1'b0);

    // K=0: clear pulse, then result after CLR quiet cycles, no accumulate.
    s0 = n_start;
    job_k     = '0;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    chk("k0_acc_reset_hi", acc_reset, 1);
    chk("k0_busy", job_busy, 1);
    @(negedge clk);
    chk("k0_acc_reset_lo", acc_reset, 0);
    chk("k0_no_result_1", res_valid, 0);
    @(negedge clk);
    chk("k0_no_result_2", res_valid, 0);
    @(negedge clk);
    chk("k0_res_valid", res_valid, 1);
    chk("k0_no_start", n_start - s0, 0);
    chk("k0_k_count", k_count, 0);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    chk("k0_busy_drop", job_busy, 0);

    // acc_done held two cycles with prod_valid always high.
    run_job(5, 2, 2, 1'b1, 1'b0, 1'b0);
    // job_start while busy is ignored; job_start with res_ack is not accepted.
    run_job(3, 3, 1, 1'b1, 1'b1, 1'b1);

    // Randomised jobs.
    for (int j = 0; j < 6; j++) begin
      run_job(int'($urandom_range(1, 8)), int'($urandom_range(1, 5)),
              int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // Largest K: k_count must reach 2^KW-1 exactly without wrapping.
    run_job((1 << KW) - 1, 1, 1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset while waiting for the third accumulate.
    done_lat  = 3;
    done_hold = 1;
    pv_always = 1'b1;
    pv_en     = 1'b1;
    job_k     = KW'(4);
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    cyc = 0;
    while (!(k_count == KW'(2) && acc_start) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reached", (k_count == KW'(2)) && acc_start, 1);
    pv_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_acc_reset", acc_reset, 1);
    chk("mid_rst_k_count", k_count, 0);
    chk("mid_rst_busy", job_busy, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_acc_start", acc_start, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_no_result", res_valid, 0);
    run_job(1, 2, 1, 1'b1, 1'b0, 1'b0);

`ifdef ACC_TIMEOUT_EN
    // Accumulator never answers: abort after TO cycles with res_err.
    never_done = 1'b1;
    pv_always  = 1'b1;
    pv_en      = 1'b1;
    job_k      = KW'(2);
    job_start  = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    cyc = 0;
    while (!acc_start && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_start_seen", acc_start, 1);
    cyc = 0;
    while (!acc_reset && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_cycles", cyc, TO);
    chk("to_res_valid", res_valid, 1);
    chk("to_res_err", res_err, 1);
    @(negedge clk);
    chk("to_acc_reset_pulse", acc_reset, 0);
    chk("to_res_err_held", res_err, 1);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack    = 1'b0;
    pv_en      = 1'b0;
    never_done = 1'b0;
    chk("to_err_until_start", res_err, 1);
    run_job(2, 2, 1, 1'b1, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
